pwm_shadow: RTL and testbench

- Multi-channel PWM generator with double-buffered (shadow) configuration, so duty, period and repeat changes apply glitch-free at a period boundary.
- Each channel selects edge-aligned or center-aligned counting.
- Each channel has explicit start and stop, and a sticky done flag.
- Sits under timer/motor/LED control blocks; configuration is driven from a register file.

---
 rtl/pwm_shadow_if.sv | 36 +++
 rtl/pwm_shadow.sv | 187 ++++++++++++++++++
 tb/tb_pwm_shadow.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/pwm_shadow_if.sv
// Bus bundle for pwm_shadow: per-channel control pulses, packed config slices and status.
// The o_period_end member exists only when PWM_PERIOD_PULSE_EN is defined.
interface pwm_shadow_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0]       i_start;
  logic [CHANNELS-1:0]       i_stop;
  logic [CHANNELS-1:0]       i_center;
  logic [CHANNELS-1:0]       i_load;
  logic [CHANNELS*WIDTH-1:0] i_duty;
  logic [CHANNELS*WIDTH-1:0] i_period;
  logic [CHANNELS*WIDTH-1:0] i_repeat_count;
  logic [CHANNELS-1:0]       o_busy;
  logic [CHANNELS-1:0]       o_done;
  logic [CHANNELS-1:0]       o_pwm;
`ifdef PWM_PERIOD_PULSE_EN
  logic [CHANNELS-1:0]       o_period_end;
`endif

  modport master (
`ifdef PWM_PERIOD_PULSE_EN
    input  o_period_end,
`endif
    output i_start, i_stop, i_center, i_load, i_duty, i_period, i_repeat_count,
    input  o_busy, o_done, o_pwm
  );

  modport slave (
`ifdef PWM_PERIOD_PULSE_EN
    output o_period_end,
`endif
    input  i_start, i_stop, i_center, i_load, i_duty, i_period, i_repeat_count,
    output o_busy, o_done, o_pwm
  );
endinterface

// File: rtl/pwm_shadow.sv
// Multi-channel PWM with shadow config applied at period boundaries, edge/center modes,
// start/stop and sticky done. Define PWM_PERIOD_PULSE_EN to add the o_period_end pulse.
module pwm_shadow #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  pwm_shadow_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q      [CHANNELS];
  state_t           state_d      [CHANNELS];
  logic [WIDTH-1:0] cnt_q        [CHANNELS];
  logic [WIDTH-1:0] cnt_d        [CHANNELS];
  logic [WIDTH-1:0] rep_q        [CHANNELS];
  logic [WIDTH-1:0] rep_d        [CHANNELS];
  logic [WIDTH-1:0] act_duty_q   [CHANNELS];
  logic [WIDTH-1:0] act_duty_d   [CHANNELS];
  logic [WIDTH-1:0] act_period_q [CHANNELS];
  logic [WIDTH-1:0] act_period_d [CHANNELS];
  logic [WIDTH-1:0] act_rep_q    [CHANNELS];
  logic [WIDTH-1:0] act_rep_d    [CHANNELS];
  logic [WIDTH-1:0] sh_duty_q    [CHANNELS];
  logic [WIDTH-1:0] sh_duty_d    [CHANNELS];
  logic [WIDTH-1:0] sh_period_q  [CHANNELS];
  logic [WIDTH-1:0] sh_period_d  [CHANNELS];
  logic [WIDTH-1:0] sh_rep_q     [CHANNELS];
  logic [WIDTH-1:0] sh_rep_d     [CHANNELS];
  logic [CHANNELS-1:0] center_q, center_d;
  logic [CHANNELS-1:0] down_q, down_d;
  logic [CHANNELS-1:0] pending_q, pending_d;
  logic [CHANNELS-1:0] pwm_q, pwm_d;
  logic [CHANNELS-1:0] done_q, done_d;
  logic [CHANNELS-1:0] busy;
  logic [CHANNELS-1:0] at_top;
  logic [CHANNELS-1:0] bnd;
`ifdef PWM_PERIOD_PULSE_EN
  logic [CHANNELS-1:0] pe_q, pe_d;
`endif

  // Center mode holds the top count for two cycles (end of up, start of down).
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      at_top[i] = (cnt_q[i] == act_period_q[i] - WIDTH'(1));
      bnd[i]    = center_q[i] ? (down_q[i] && (cnt_q[i] == '0)) : at_top[i];
      busy[i]   = (state_q[i] == S_RUN);
    end
  end

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      state_d[i]      = state_q[i];
      cnt_d[i]        = cnt_q[i];
      rep_d[i]        = rep_q[i];
      act_duty_d[i]   = act_duty_q[i];
      act_period_d[i] = act_period_q[i];
      act_rep_d[i]    = act_rep_q[i];
      sh_duty_d[i]    = sh_duty_q[i];
      sh_period_d[i]  = sh_period_q[i];
      sh_rep_d[i]     = sh_rep_q[i];
      center_d[i]     = center_q[i];
      down_d[i]       = down_q[i];
      pending_d[i]    = pending_q[i];
      pwm_d[i]        = 1'b0;
      done_d[i]       = done_q[i];
`ifdef PWM_PERIOD_PULSE_EN
      pe_d[i]         = 1'b0;
`endif

      if (state_q[i] == S_RUN) begin
        pwm_d[i] = (act_duty_q[i] >= act_period_q[i]) || (cnt_q[i] < act_duty_q[i]);
        if (!center_q[i]) begin
          cnt_d[i] = at_top[i] ? '0 : cnt_q[i] + WIDTH'(1);
        end else if (!down_q[i]) begin
          if (at_top[i]) down_d[i] = 1'b1;
          else           cnt_d[i]  = cnt_q[i] + WIDTH'(1);
        end else if (cnt_q[i] != '0) begin
          cnt_d[i] = cnt_q[i] - WIDTH'(1);
        end

        if (bnd[i]) begin
`ifdef PWM_PERIOD_PULSE_EN
          pe_d[i]  = 1'b1;
`endif
          cnt_d[i]  = '0;
          down_d[i] = 1'b0;
          // A pending transfer restarts the repeat count, so it never ends the run.
          if (pending_q[i]) begin
            act_duty_d[i]   = sh_duty_q[i];
            act_period_d[i] = sh_period_q[i];
            act_rep_d[i]    = sh_rep_q[i];
            center_d[i]     = bus.i_center[i];
            pending_d[i]    = 1'b0;
            rep_d[i]        = '0;
          end else if ((act_rep_q[i] != '0) && (rep_q[i] + WIDTH'(1) == act_rep_q[i])) begin
            state_d[i] = S_DONE;
            done_d[i]  = 1'b1;
            rep_d[i]   = '0;
          end else begin
            rep_d[i] = rep_q[i] + WIDTH'(1);
          end
        end
      end else if (bus.i_start[i] && (sh_period_q[i] != '0)) begin
        state_d[i]      = S_RUN;
        act_duty_d[i]   = sh_duty_q[i];
        act_period_d[i] = sh_period_q[i];
        act_rep_d[i]    = sh_rep_q[i];
        center_d[i]     = bus.i_center[i];
        pending_d[i]    = 1'b0;
        cnt_d[i]        = '0;
        rep_d[i]        = '0;
        down_d[i]       = 1'b0;
        done_d[i]       = 1'b0;
      end

      if (bus.i_stop[i]) begin
        state_d[i] = S_IDLE;
        cnt_d[i]   = '0;
        rep_d[i]   = '0;
        down_d[i]  = 1'b0;
        done_d[i]  = 1'b0;
        pwm_d[i]   = 1'b0;
      end

      // Load lands after the transfer so a same-cycle load stays pending.
      if (bus.i_load[i]) begin
        sh_duty_d[i]   = bus.i_duty[i*WIDTH +: WIDTH];
        sh_period_d[i] = bus.i_period[i*WIDTH +: WIDTH];
        sh_rep_d[i]    = bus.i_repeat_count[i*WIDTH +: WIDTH];
        pending_d[i]   = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i]      <= S_IDLE;
        cnt_q[i]        <= '0;
        rep_q[i]        <= '0;
        act_duty_q[i]   <= '0;
        act_period_q[i] <= '0;
        act_rep_q[i]    <= '0;
        sh_duty_q[i]    <= '0;
        sh_period_q[i]  <= '0;
        sh_rep_q[i]     <= '0;
      end
      center_q  <= '0;
      down_q    <= '0;
      pending_q <= '0;
      pwm_q     <= '0;
      done_q    <= '0;
`ifdef PWM_PERIOD_PULSE_EN
      pe_q      <= '0;
`endif
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i]      <= state_d[i];
        cnt_q[i]        <= cnt_d[i];
        rep_q[i]        <= rep_d[i];
        act_duty_q[i]   <= act_duty_d[i];
        act_period_q[i] <= act_period_d[i];
        act_rep_q[i]    <= act_rep_d[i];
        sh_duty_q[i]    <= sh_duty_d[i];
        sh_period_q[i]  <= sh_period_d[i];
        sh_rep_q[i]     <= sh_rep_d[i];
      end
      center_q  <= center_d;
      down_q    <= down_d;
      pending_q <= pending_d;
      pwm_q     <= pwm_d;
      done_q    <= done_d;
`ifdef PWM_PERIOD_PULSE_EN
      pe_q      <= pe_d;
`endif
    end
  end

  assign bus.o_busy = busy;
  assign bus.o_done = done_q;
  assign bus.o_pwm  = pwm_q;
`ifdef PWM_PERIOD_PULSE_EN
  assign bus.o_period_end = pe_q;
`endif
endmodule

// File: tb/tb_pwm_shadow.sv
// Directed bench for pwm_shadow: table of single-run scenarios plus hand-written
// sequences for shadow update, control conflicts and asynchronous reset.
module tb_pwm_shadow;
  localparam int W = 8;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  pwm_shadow_if #(.WIDTH(W), .CHANNELS(N)) bus ();
  pwm_shadow #(.WIDTH(W), .CHANNELS(N)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Strings list expected values for cycle 1, 2, ... after the start edge.
  typedef struct {
    string      name;
    int         ch;
    bit         center;
    logic [7:0] d;
    logic [7:0] p;
    logic [7:0] r;
    string      pwm_s;
    string      busy_s;
    string      done_s;
  } vec_t;

  vec_t vecs [7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic bit_of(input string s, input int k);
    return (s[k] == "1");
  endfunction

  task automatic set_cfg(input int ch, input bit c, input logic [7:0] d,
                         input logic [7:0] p, input logic [7:0] r);
    bus.i_duty[ch*W +: W]         = d;
    bus.i_period[ch*W +: W]       = p;
    bus.i_repeat_count[ch*W +: W] = r;
    bus.i_center[ch]              = c;
  endtask

  initial begin
    string s1, pe1, s2;
    bus.i_start = '0; bus.i_stop = '0; bus.i_center = '0; bus.i_load = '0;
    bus.i_duty = '0; bus.i_period = '0; bus.i_repeat_count = '0;

    vecs[0] = '{"edge_d3p8r2",   0, 1'b0, 8'd3, 8'd8, 8'd2,
                "01110000011100000000", "11111111111111110000", "00000000000000001111"};
    vecs[1] = '{"center_d2p5r1", 1, 1'b1, 8'd2, 8'd5, 8'd1,
                "01100000011000", "11111111110000", "00000000001111"};
    vecs[2] = '{"duty0",         3, 1'b0, 8'd0, 8'd4, 8'd1,
                "0000000", "1111000", "0000111"};
    vecs[3] = '{"duty_ge_p",     0, 1'b0, 8'd9, 8'd8, 8'd1,
                "01111111100", "11111111000", "00000000111"};
    vecs[4] = '{"p1_edge_r3",    2, 1'b0, 8'd1, 8'd1, 8'd3,
                "011100", "111000", "000111"};
    vecs[5] = '{"p1_center_r1",  1, 1'b1, 8'd1, 8'd1, 8'd1,
                "01100", "11000", "00111"};
    vecs[6] = '{"p0_start",      3, 1'b0, 8'd5, 8'd0, 8'd1,
                "000", "000", "000"};

    step(); step();
    rst = 1'b0;
    step();
    check("reset_busy", 32'(bus.o_busy), 32'h0);
    check("reset_done", 32'(bus.o_done), 32'h0);
    check("reset_pwm",  32'(bus.o_pwm),  32'h0);

    foreach (vecs[v]) begin
      set_cfg(vecs[v].ch, vecs[v].center, vecs[v].d, vecs[v].p, vecs[v].r);
      bus.i_load[vecs[v].ch] = 1'b1;
      step();
      bus.i_load = '0;
      bus.i_start[vecs[v].ch] = 1'b1;
      step();
      bus.i_start = '0;
      for (int k = 0; k < vecs[v].pwm_s.len(); k++) begin
        check({vecs[v].name, "_pwm"},  32'(bus.o_pwm[vecs[v].ch]),  32'(bit_of(vecs[v].pwm_s, k)));
        check({vecs[v].name, "_busy"}, 32'(bus.o_busy[vecs[v].ch]), 32'(bit_of(vecs[v].busy_s, k)));
        check({vecs[v].name, "_done"}, 32'(bus.o_done[vecs[v].ch]), 32'(bit_of(vecs[v].done_s, k)));
        step();
      end
      bus.i_stop[vecs[v].ch] = 1'b1;
      step();
      bus.i_stop = '0;
      check({vecs[v].name, "_stop_done"}, 32'(bus.o_done[vecs[v].ch]), 32'h0);
    end

    // Shadow update on ch2: D=2 P=4 forever, D=3 loaded mid-period.
    set_cfg(2, 1'b0, 8'd2, 8'd4, 8'd0);
    bus.i_load[2] = 1'b1; step(); bus.i_load = '0;
    bus.i_start[2] = 1'b1; step(); bus.i_start = '0;   // cycle 1
    step();                                            // cycle 2
    bus.i_duty[2*W +: W] = 8'd3;
    bus.i_load[2] = 1'b1; step(); bus.i_load = '0;     // cycle 3
    s1  = "1001110";
    pe1 = "0010001";
    for (int k = 0; k < 7; k++) begin
      check("shadow_mid_pwm", 32'(bus.o_pwm[2]), 32'(bit_of(s1, k)));
`ifdef PWM_PERIOD_PULSE_EN
      check("period_end", 32'(bus.o_period_end[2]), 32'(bit_of(pe1, k)));
`endif
      step();
    end                                                // cycle 10
    step(); step();                                    // cycle 12, boundary cycle
    bus.i_duty[2*W +: W] = 8'd1;
    bus.i_load[2] = 1'b1; step(); bus.i_load = '0;     // cycle 13
    s2 = "011101000";
    for (int k = 0; k < 9; k++) begin
      check("shadow_bnd_pwm", 32'(bus.o_pwm[2]), 32'(bit_of(s2, k)));
      step();
    end                                                // cycle 22
    check("forever_busy", 32'(bus.o_busy[2]), 32'h1);
    check("forever_done", 32'(bus.o_done[2]), 32'h0);
    bus.i_start[2] = 1'b1; step(); bus.i_start = '0;   // cycle 23
    step();                                            // cycle 24
    check("start_in_run_pwm",  32'(bus.o_pwm[2]),  32'h0);
    check("start_in_run_busy", 32'(bus.o_busy[2]), 32'h1);
    step();                                            // cycle 25, cnt 0
    bus.i_stop[2] = 1'b1; step(); bus.i_stop = '0;     // cycle 26
    check("stop_mid_pwm",  32'(bus.o_pwm[2]),  32'h0);
    check("stop_mid_busy", 32'(bus.o_busy[2]), 32'h0);
    check("stop_mid_done", 32'(bus.o_done[2]), 32'h0);

    // Stop and start together on ch0 (shadow still holds P=8).
    bus.i_start[0] = 1'b1; bus.i_stop[0] = 1'b1;
    step();
    bus.i_start = '0; bus.i_stop = '0;
    check("stop_start_busy", 32'(bus.o_busy[0]), 32'h0);
    step();
    check("stop_start_pwm",  32'(bus.o_pwm[0]),  32'h0);
    check("stop_start_busy2", 32'(bus.o_busy[0]), 32'h0);

    // Asynchronous reset while all channels run.
    for (int c = 0; c < N; c++) set_cfg(c, 1'b0, 8'd9, 8'd8, 8'd0);
    bus.i_load = '1; step(); bus.i_load = '0;
    bus.i_start = '1; step(); bus.i_start = '0;
    step();
    check("all_run_busy", 32'(bus.o_busy), 32'hF);
    check("all_run_pwm",  32'(bus.o_pwm),  32'hF);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_busy", 32'(bus.o_busy), 32'h0);
    check("async_rst_pwm",  32'(bus.o_pwm),  32'h0);
    check("async_rst_done", 32'(bus.o_done), 32'h0);
    #2;
    rst = 1'b0;
    step();
    bus.i_start = '1; step(); bus.i_start = '0;
    check("empty_shadow_busy", 32'(bus.o_busy), 32'h0);
    step();
    check("empty_shadow_busy2", 32'(bus.o_busy), 32'h0);
    check("empty_shadow_pwm",   32'(bus.o_pwm),  32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
